// File: rtl/cart_bus_pkg.sv
// Shared types and helpers for the cartridge bus arbiter.
// The round-robin picker is written for NPORTS so a third requester can be added later.
package cart_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_RISE,
      WAIT_FALL,
      DONE,
      ABORT
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   localparam logic [7:0] ABORT_RDATA = 8'hFF;
   localparam int         NPORTS      = 2;
   localparam int         PIDX_W      = 1;

   // Highest priority goes to the port just after 'last', wrapping around.
   function automatic logic [NPORTS-1:0] rr_pick(input logic [NPORTS-1:0] req,
                                                 input logic [PIDX_W-1:0] last);
      logic [NPORTS-1:0] pick;
      logic [PIDX_W-1:0] idx;
      pick = '0;
      for (int k = NPORTS; k >= 1; k--) begin
         idx = PIDX_W'((int'(last) + k) % NPORTS);
         if (req[idx]) begin
            pick      = '0;
            pick[idx] = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/cart_bus_arbiter.sv
// Two-port round-robin arbiter for the cartridge bus: issues one rd/wr strobe,
// follows cart busy to completion and returns data with a one-cycle ack.
module cart_bus_arbiter
   import cart_bus_pkg::*;
#(
   parameter int BSY_RISE_WAIT  = 3,
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int TO_W           = 10
) (
   input  logic        i_clk_8m,
   input  logic        i_rst_n,
   input  logic        i_handover,
   input  logic        i_p0_rd,
   input  logic        i_p0_wr,
   input  logic [15:0] i_p0_addr,
   input  logic [7:0]  i_p0_wdata,
   output logic [7:0]  o_p0_rdata,
   output logic        o_p0_ack,
   output logic        o_p0_err,
   input  logic        i_p1_rd,
   input  logic        i_p1_wr,
   input  logic [15:0] i_p1_addr,
   input  logic [7:0]  i_p1_wdata,
   output logic [7:0]  o_p1_rdata,
   output logic        o_p1_ack,
   output logic        o_p1_err,
   output logic        o_cart_rd,
   output logic        o_cart_wr,
   output logic [15:0] o_cart_addr,
   output logic [7:0]  o_cart_din,
   input  logic [7:0]  i_cart_dout,
   input  logic        i_cart_busy,
   output logic [1:0]  o_grant
);

   // The counter runs from the ISSUE cycle, so its value is the cycle count since the strobe.
   localparam logic [TO_W-1:0] RISE_LIM  = TO_W'(BSY_RISE_WAIT);
   localparam logic [TO_W-1:0] ABORT_LIM = TO_W'(TIMEOUT_CYCLES - 1);

   state_t              r_state;
   op_t                 r_op;
   logic                r_lockout;
   logic [PIDX_W-1:0]   r_last_grant;
   logic [NPORTS-1:0]   r_grant;
   logic                r_cart_rd;
   logic                r_cart_wr;
   logic [15:0]         r_cart_addr;
   logic [7:0]          r_cart_din;
   logic [TO_W-1:0]     r_cnt;
   logic [NPORTS-1:0]   r_ack;
   logic [NPORTS-1:0]   r_err;
   logic [7:0]          r_rdata [NPORTS];

   logic [NPORTS-1:0]   w_rd;
   logic [NPORTS-1:0]   w_wr;
   logic [NPORTS-1:0]   w_req;
   logic [NPORTS-1:0]   w_pick;
   logic [15:0]         w_addr  [NPORTS];
   logic [7:0]          w_wdata [NPORTS];
   logic [PIDX_W-1:0]   w_sel;
   logic [PIDX_W-1:0]   w_owner;
   logic                w_done;
   logic                w_abort;

   assign w_rd       = {i_p1_rd, i_p0_rd};
   assign w_wr       = {i_p1_wr, i_p0_wr};
   assign w_addr[0]  = i_p0_addr;
   assign w_addr[1]  = i_p1_addr;
   assign w_wdata[0] = i_p0_wdata;
   assign w_wdata[1] = i_p1_wdata;

   assign w_req   = (w_rd | w_wr) & {1'b1, ~r_lockout};
   assign w_pick  = rr_pick(w_req, r_last_grant);
   assign w_sel   = w_pick[1];
   assign w_owner = r_grant[1];

   // A zero-wait cart never raises busy; the transfer is then treated as complete.
   assign w_done  = ((r_state == WAIT_RISE) && !i_cart_busy && (r_cnt == RISE_LIM)) ||
                    ((r_state == WAIT_FALL) && !i_cart_busy);
   assign w_abort = (r_state == WAIT_FALL) && i_cart_busy && (r_cnt == ABORT_LIM);

   always_ff @(posedge i_clk_8m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_op         <= OP_RD;
         r_lockout    <= 1'b0;
         r_last_grant <= PIDX_W'(1);
         r_grant      <= '0;
         r_cart_rd    <= 1'b0;
         r_cart_wr    <= 1'b0;
         r_cart_addr  <= '0;
         r_cart_din   <= '0;
         r_cnt        <= '0;
         r_ack        <= '0;
         r_err        <= '0;
         for (int p = 0; p < NPORTS; p++) begin
            r_rdata[p] <= '0;
         end
      end else begin
         r_cart_rd <= 1'b0;
         r_cart_wr <= 1'b0;
         r_ack     <= '0;
         r_err     <= '0;
         r_lockout <= r_lockout | i_handover;

         case (r_state)
            IDLE: begin
               if (|w_req) begin
                  r_state     <= ISSUE;
                  r_grant     <= w_pick;
                  r_op        <= w_wr[w_sel] ? OP_WR : OP_RD;
                  r_cart_addr <= w_addr[w_sel];
                  r_cart_din  <= w_wdata[w_sel];
                  r_cart_rd   <= ~w_wr[w_sel];
                  r_cart_wr   <= w_wr[w_sel];
                  r_cnt       <= '0;
               end
            end
            ISSUE: begin
               r_state <= WAIT_RISE;
               r_cnt   <= r_cnt + 1'b1;
            end
            WAIT_RISE: begin
               r_cnt <= r_cnt + 1'b1;
               if (i_cart_busy) begin
                  r_state <= WAIT_FALL;
               end
            end
            WAIT_FALL: begin
               r_cnt <= r_cnt + 1'b1;
            end
            DONE, ABORT: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase

         // Ack, data and grant release are all registered on entry to DONE/ABORT.
         if (w_done || w_abort) begin
            r_state        <= w_abort ? ABORT : DONE;
            r_grant        <= '0;
            r_last_grant   <= w_owner;
            r_ack[w_owner] <= 1'b1;
            r_err[w_owner] <= w_abort;
            if (w_abort) begin
               r_rdata[w_owner] <= ABORT_RDATA;
            end else begin
               r_rdata[w_owner] <= (r_op == OP_WR) ? 8'h00 : i_cart_dout;
            end
         end
      end
   end

   assign o_p0_rdata  = r_rdata[0];
   assign o_p0_ack    = r_ack[0];
   assign o_p0_err    = r_err[0];
   assign o_p1_rdata  = r_rdata[1];
   assign o_p1_ack    = r_ack[1];
   assign o_p1_err    = r_err[1];
   assign o_cart_rd   = r_cart_rd;
   assign o_cart_wr   = r_cart_wr;
   assign o_cart_addr = r_cart_addr;
   assign o_cart_din  = r_cart_din;
   assign o_grant     = r_grant;

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Directed bench for cart_bus_arbiter with a small programmable cart busy model.
// Expected values are hand-derived from the arbiter's cycle-level behaviour.
module tb_cart_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        handover = 1'b0;
   logic        p0_rd = 1'b0, p0_wr = 1'b0, p1_rd = 1'b0, p1_wr = 1'b0;
   logic [15:0] p0_addr = '0, p1_addr = '0;
   logic [7:0]  p0_wdata = '0, p1_wdata = '0;
   logic [7:0]  p0_rdata, p1_rdata;
   logic        p0_ack, p0_err, p1_ack, p1_err;
   logic        cart_rd, cart_wr;
   logic [15:0] cart_addr;
   logic [7:0]  cart_din;
   logic [7:0]  cart_dout = '0;
   logic        cart_busy = 1'b0;
   logic [1:0]  grant;

   int n_vec = 0;
   int n_bad = 0;
   int lat;
   int p0_acks = 0;
   int acks_before;

   // cart busy model: rises busy_dly cycles after the strobe cycle, stays busy_len cycles
   int cyc = 0, b_start = 0, b_end = 0, busy_dly = 2, busy_len = 2;

   cart_bus_arbiter dut (
      .i_clk_8m   (clk),
      .i_rst_n    (rst_n),
      .i_handover (handover),
      .i_p0_rd    (p0_rd),
      .i_p0_wr    (p0_wr),
      .i_p0_addr  (p0_addr),
      .i_p0_wdata (p0_wdata),
      .o_p0_rdata (p0_rdata),
      .o_p0_ack   (p0_ack),
      .o_p0_err   (p0_err),
      .i_p1_rd    (p1_rd),
      .i_p1_wr    (p1_wr),
      .i_p1_addr  (p1_addr),
      .i_p1_wdata (p1_wdata),
      .o_p1_rdata (p1_rdata),
      .o_p1_ack   (p1_ack),
      .o_p1_err   (p1_err),
      .o_cart_rd  (cart_rd),
      .o_cart_wr  (cart_wr),
      .o_cart_addr(cart_addr),
      .o_cart_din (cart_din),
      .i_cart_dout(cart_dout),
      .i_cart_busy(cart_busy),
      .o_grant    (grant)
   );

   always #5 clk = ~clk;

   always begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (cart_rd || cart_wr) begin
         b_start = cyc + busy_dly;
         b_end   = b_start + busy_len;
      end
      if (!rst_n) b_end = 0;
      cart_busy = rst_n && (cyc >= b_start) && (cyc < b_end);
   end

   always @(negedge clk) begin
      if (p0_ack) p0_acks = p0_acks + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %-16s got 0x%0h exp 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %-16s 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ack(input int start, input int budget, output int n);
      n = start;
      while (!(p0_ack || p1_ack) && n < budget) begin
         tick();
         n++;
      end
      if (!(p0_ack || p1_ack)) chk("ack_timeout", 0, 1);
   endtask

   task automatic wait_grant(input int budget);
      int n = 0;
      while (grant == 2'b00 && n < budget) begin
         tick();
         n++;
      end
      if (grant == 2'b00) chk("grant_timeout", 0, 1);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      b_end     = 0;
      cart_busy = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got 0x0 exp 0x1");
      $fatal(1, "bench timeout");
   end

   initial begin
      // reset state
      #1 rst_n = 1'b0;
      repeat (2) tick();
      chk("rst_grant", grant, 2'b00);
      chk("rst_cart_rd", cart_rd, 0);
      chk("rst_cart_wr", cart_wr, 0);
      chk("rst_acks", {p1_ack, p0_ack}, 0);
      chk("rst_rdata", {p1_rdata, p0_rdata}, 0);
      rst_n = 1'b1;
      tick();
      chk("rst_idle_grant", grant, 2'b00);

      // T1: single p0 read, 2-cycle busy, request-to-ack = 6
      busy_dly = 2; busy_len = 2; cart_dout = 8'h3C;
      p0_rd = 1'b1; p0_addr = 16'h0104;
      tick();
      chk("t1_strobe", cart_rd, 1);
      chk("t1_addr", cart_addr, 16'h0104);
      chk("t1_grant", grant, 2'b01);
      tick();
      chk("t1_strobe_end", cart_rd, 0);
      wait_ack(2, 40, lat);
      chk("t1_latency", lat, 6);
      chk("t1_p0_ack", p0_ack, 1);
      chk("t1_p1_ack", p1_ack, 0);
      chk("t1_rdata", p0_rdata, 8'h3C);
      chk("t1_err", p0_err, 0);
      chk("t1_grant_rel", grant, 2'b00);
      p0_rd = 1'b0;
      tick();
      chk("t1_ack_pulse", p0_ack, 0);
      chk("t1_rdata_hold", p0_rdata, 8'h3C);

      // T2: both ports reading continuously -> 01,10,01,10
      do_reset();
      p0_rd = 1'b1; p0_addr = 16'h1111;
      p1_rd = 1'b1; p1_addr = 16'h2222;
      for (int k = 0; k < 4; k++) begin
         wait_grant(10);
         chk("t2_grant", grant, (k % 2 == 0) ? 2'b01 : 2'b10);
         chk("t2_addr", cart_addr, (k % 2 == 0) ? 16'h1111 : 16'h2222);
         cart_dout = 8'(8'h10 + k);
         wait_ack(0, 40, lat);
         chk("t2_owner_ack", (k % 2 == 0) ? p0_ack : p1_ack, 1);
         chk("t2_other_ack", (k % 2 == 0) ? p1_ack : p0_ack, 0);
         chk("t2_rdata", (k % 2 == 0) ? p0_rdata : p1_rdata, 32'h10 + k);
         if (k == 3) begin
            p0_rd = 1'b0;
            p1_rd = 1'b0;
         end
         tick();
      end

      // T3: p1 write (rd also high -> write wins), busy never rises
      busy_len = 0;
      p1_rd = 1'b1; p1_wr = 1'b1; p1_addr = 16'h2000; p1_wdata = 8'h05;
      tick();
      chk("t3_wr_strobe", cart_wr, 1);
      chk("t3_no_rd", cart_rd, 0);
      chk("t3_addr", cart_addr, 16'h2000);
      chk("t3_din", cart_din, 8'h05);
      chk("t3_grant", grant, 2'b10);
      tick();
      chk("t3_strobe_end", cart_wr, 0);
      wait_ack(2, 40, lat);
      chk("t3_latency", lat, 5);
      chk("t3_p1_ack", p1_ack, 1);
      chk("t3_err", p1_err, 0);
      chk("t3_rdata", p1_rdata, 8'h00);
      p1_rd = 1'b0; p1_wr = 1'b0;
      tick();

      // T4: busy stuck high -> abort at 1023 cycles after ISSUE
      busy_dly = 1; busy_len = 100000; cart_dout = 8'h77;
      p1_rd = 1'b1; p1_addr = 16'h3000;
      tick();
      chk("t4_grant", grant, 2'b10);
      wait_ack(1, 1200, lat);
      chk("t4_latency", lat, 1024);
      chk("t4_p1_ack", p1_ack, 1);
      chk("t4_err", p1_err, 1);
      chk("t4_rdata", p1_rdata, 8'hFF);
      p1_rd = 1'b0;
      b_end = 0;
      cart_busy = 1'b0;
      tick();
      chk("t4_err_pulse", p1_err, 0);
      busy_dly = 2; busy_len = 2; cart_dout = 8'h42;
      p1_rd = 1'b1; p1_addr = 16'h3001;
      wait_ack(0, 40, lat);
      chk("t4_next_lat", lat, 6);
      chk("t4_next_err", p1_err, 0);
      chk("t4_next_rdata", p1_rdata, 8'h42);
      p1_rd = 1'b0;
      tick();

      // T5: handover during an in-flight p0 read
      cart_dout = 8'h99;
      p0_rd = 1'b1; p0_addr = 16'h0200;
      tick();
      chk("t5_grant", grant, 2'b01);
      handover = 1'b1;
      tick();
      wait_ack(2, 40, lat);
      chk("t5_latency", lat, 6);
      chk("t5_p0_ack", p0_ack, 1);
      chk("t5_err", p0_err, 0);
      chk("t5_rdata", p0_rdata, 8'h99);
      p0_rd = 1'b0; handover = 1'b0;
      tick();
      acks_before = p0_acks;
      p0_rd = 1'b1; p0_addr = 16'h0300;
      p1_rd = 1'b1; p1_addr = 16'h0400;
      for (int k = 0; k < 3; k++) begin
         wait_grant(10);
         chk("t5_p1_grant", grant, 2'b10);
         cart_dout = 8'(8'h60 + k);
         wait_ack(0, 40, lat);
         chk("t5_p1_ack", p1_ack, 1);
         chk("t5_p1_rdata", p1_rdata, 32'h60 + k);
         tick();
      end
      p1_rd = 1'b0;
      repeat (20) tick();
      chk("t5_idle_grant", grant, 2'b00);
      chk("t5_p0_locked", p0_acks, acks_before);

      // T6: async reset during WAIT_FALL, then port 0 served again
      busy_dly = 1; busy_len = 100000; cart_dout = 8'hAB;
      p1_rd = 1'b1; p1_addr = 16'h0500;
      wait_grant(10);
      repeat (3) tick();
      chk("t6_busy_seen", cart_busy, 1);
      chk("t6_grant_pre", grant, 2'b10);
      #2;
      rst_n = 1'b0;
      b_end = 0;
      cart_busy = 1'b0;
      #1;
      chk("t6_grant_async", grant, 2'b00);
      chk("t6_strobes", {cart_wr, cart_rd}, 0);
      chk("t6_acks", {p1_ack, p0_ack}, 0);
      p1_rd = 1'b0;
      tick();
      tick();
      chk("t6_acks_held", {p1_ack, p0_ack}, 0);
      busy_dly = 2; busy_len = 2; cart_dout = 8'hCD;
      rst_n = 1'b1;
      wait_ack(0, 40, lat);
      chk("t6_p0_lat", lat, 6);
      chk("t6_p0_ack", p0_ack, 1);
      chk("t6_p0_rdata", p0_rdata, 8'hCD);
      chk("t6_p1_ack", p1_ack, 0);
      p0_rd = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/cart_bus_arbiter.md
Name: cart_bus_arbiter

Overview:
- Shares the single cartridge bus interface between two requesters and sequences each transfer: port 0 is the startup screen generator, port 1 is the SPI cart bridge.
- Replaces the static startup_done mux with a handshaked arbiter, so both requesters can coexist safely during handover.
- Issues one rd/wr strobe to the cart interface and tracks its busy signal to completion.
- Returns read data with a one-cycle ack, and recovers from a hung transfer with a watchdog.

Parameters:
- BSY_RISE_WAIT, 3: cycles after the strobe to wait for cart busy to rise before treating the transfer as already complete.
- TIMEOUT_CYCLES, 1023: maximum cycles busy may stay high before the transfer is aborted.
- TO_W, 10: width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- clk_8m  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- handover  in  1  level; when 1, port 0 is locked out permanently until reset.
- p0_rd  in  1  port 0 read request, level, held until p0_ack.
- p0_wr  in  1  port 0 write request, level, held until p0_ack.
- p0_addr  in  16  port 0 address.
- p0_wdata  in  8  port 0 write data.
- p0_rdata  out  8  port 0 read data, valid when p0_ack=1.
- p0_ack  out  1  one-cycle completion pulse.
- p0_err  out  1  qualifies p0_ack; 1 = transfer aborted by watchdog.
- p1_rd, p1_wr, p1_addr, p1_wdata, p1_rdata, p1_ack, p1_err: same as port 0.
- cart_rd  out  1  read strobe to the cart interface.
- cart_wr  out  1  write strobe to the cart interface.
- cart_addr  out  16  registered address to the cart interface.
- cart_din  out  8  registered write data to the cart interface.
- cart_dout  in  8  read data from the cart interface.
- cart_busy  in  1  cart interface busy.
- grant  out  2  one-hot owner of the in-flight transfer; 00 when idle.

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant=1, so port 0 wins the first tie; lockout=0.
- lockout sets on the first clk_8m edge with handover=1 and clears only on reset.
- Request valid: pN_req = pN_rd | pN_wr. Port 0 is additionally masked by lockout.
- If rd and wr are both high on a port, the transfer is a write.
- Arbitration happens only in IDLE.
  - One valid request: grant it.
  - Both valid: round-robin; grant the port not equal to last_grant.
- IDLE -> ISSUE when any request is valid. On entry, latch:
  - grant,
  - op = write/read,
  - cart_addr and cart_din from the granted port.
- Request and address changes after latching are ignored until ack.
- ISSUE (1 cycle): cart_rd or cart_wr = 1 for exactly this cycle. Next state WAIT_RISE; the watchdog counter is cleared.
- WAIT_RISE:
  - cart_busy=1 -> WAIT_FALL.
  - If busy has not risen within BSY_RISE_WAIT cycles -> DONE, because the interface completed with zero wait.
- WAIT_FALL:
  - cart_busy=0 -> DONE.
  - When the counter reaches TIMEOUT_CYCLES -> ABORT.
- DONE (1 cycle):
  - pN_rdata = cart_dout, sampled this cycle, for reads; 0x00 for writes.
  - pN_ack=1 and pN_err=0 for the granted port; last_grant updated; grant=00.
  - Next state IDLE.
- ABORT (1 cycle): same as DONE except rdata=0xFF and err=1.
- Latency with an idle arbiter and a 2-cycle busy pulse: request high to ack = 6 cycles. The ack port may be re-granted in the cycle after its ack only if the other port is idle.
- handover asserting mid-transfer does not cancel an in-flight port-0 transfer; that transfer completes normally and further port-0 requests never receive ack.
- Asynchronous reset mid-transfer: strobes drop immediately and no ack is issued. The cart interface is reset by the same reset.
- pN_rdata holds its value between acks.

Decomposition:
- Shared package cart_bus_pkg holds:
  - state enum {IDLE, ISSUE, WAIT_RISE, WAIT_FALL, DONE, ABORT},
  - op encoding,
  - ABORT_RDATA=8'hFF.
- No sub-module is needed. The round-robin picker is a small function in the package, reusable when a third requester (e.g. a link-port bridge) is added.

Test Plan:
- p0_rd, addr 0x0104, busy 2 cycles, cart_dout=0x3C -> cart_rd pulses 1 cycle with cart_addr=0x0104; p0_ack with p0_rdata=0x3C at request+6 cycles; grant returns to 00.
- p0 and p1 both request reads continuously -> grants alternate 01,10,01,10 starting with port 0, and each ack goes only to the owner.
- p1_wr addr 0x2000 data 0x05, busy never rises -> cart_wr pulses once; p1_ack after BSY_RISE_WAIT+2 cycles, err=0, rdata=0x00.
- busy stuck high after a p1 read -> p1_ack with p1_err=1 and rdata=0xFF at TIMEOUT_CYCLES cycles after ISSUE; next request proceeds normally.
- handover raised during an in-flight port-0 read -> that read acks normally; a subsequent p0_rd never acks while p1 requests are served back-to-back.
- rst_n pulsed low during WAIT_FALL -> strobes, grant and acks go to 0 asynchronously; after release, lockout=0 and port 0 is served again.
